// File: rtl/ds18b20_pkg.sv
// Shared constants for the DS18B20 scratchpad frame checker: CRC polynomial,
// frame geometry, temperature byte positions and FSM state encoding.
package ds18b20_pkg;

  // Dallas/Maxim CRC-8 (x^8 + x^5 + x^4 + 1), bit-reversed for LSB-first shifting.
  localparam logic [7:0] CRC8_POLY_REFL = 8'h8C;

  localparam int FRAME_BYTES_DEFAULT = 9;
  localparam int FRAME_BITS          = FRAME_BYTES_DEFAULT * 8;

  localparam int TEMP_LSB_BYTE = 0;
  localparam int TEMP_MSB_BYTE = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  // One bit-serial CRC step, shared by the CRC engine.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[0] ^ din;
    return (crc >> 1) ^ (fb ? CRC8_POLY_REFL : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_maxim_serial.sv
// Bit-serial Dallas/Maxim CRC-8, LSB first. A frame that carries its own CRC
// byte leaves a residue of zero.
module crc8_maxim_serial
  import ds18b20_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 8'h00;
    end else if (clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= crc8_step(crc, din);
    end
  end

endmodule

// File: rtl/ds18b20_frame_check.sv
// DS18B20 scratchpad frame checker: shifts in a 72-bit LSB-first read, checks
// CRC-8, and holds the last good temperature. `DS18B20_ROUND_EN selects
// round-half-up conversion with +max saturation instead of floor.
module ds18b20_frame_check
  import ds18b20_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEFAULT,
  parameter int TEMP_W      = 8
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              bit_valid,
  input  logic              bit_data,
  output logic              busy,
  output logic              temp_valid,
  output logic              crc_err,
  output logic [15:0]       temp_raw,
  output logic [TEMP_W-1:0] temp_deg
);

  localparam int NBITS = FRAME_BYTES * 8;
  localparam int CNT_W = $clog2(NBITS);

  logic [1:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [NBITS-1:0]  frame;
  logic [7:0]        crc;
  logic              shift_en;
  logic              frame_ok;
  logic [15:0]       raw_next;
  logic [TEMP_W-1:0] deg_next;

  // frame_start always wins, so a coincident bit never reaches the CRC.
  assign shift_en = (state == ST_SHIFT) && bit_valid && !frame_start;

  crc8_maxim_serial u_crc (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .clr    (frame_start),
    .en     (shift_en),
    .din    (bit_data),
    .crc    (crc)
  );

  // A stuck-low bus yields a zero residue too, so all-zero frames are rejected.
  assign frame_ok = (crc == 8'h00) && (|frame);
  assign raw_next = {frame[TEMP_MSB_BYTE*8 +: 8], frame[TEMP_LSB_BYTE*8 +: 8]};

`ifdef DS18B20_ROUND_EN
  localparam logic signed [12:0] TEMP_MAX = 13'((1 << (TEMP_W - 1)) - 1);
  logic signed [12:0] rounded;
  assign rounded  = $signed({raw_next[15], raw_next[15:4]}) + $signed({12'd0, raw_next[3]});
  assign deg_next = (rounded > TEMP_MAX) ? TEMP_MAX[TEMP_W-1:0] : rounded[TEMP_W-1:0];
`else
  assign deg_next = raw_next[TEMP_W+3:4];
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      // NOTE: the frame shifter is reset with everything else; it is a
      // register, not a memory, and async reset must clear the held value too.
      frame      <= '0;
      busy       <= 1'b0;
      temp_valid <= 1'b0;
      crc_err    <= 1'b0;
      temp_raw   <= 16'h0000;
      temp_deg   <= '0;
    end else begin
      temp_valid <= 1'b0;
      crc_err    <= 1'b0;
      if (frame_start) begin
        state   <= ST_SHIFT;
        bit_cnt <= '0;
        busy    <= 1'b1;
      end else begin
        case (state)
          ST_SHIFT: begin
            if (bit_valid) begin
              frame <= {bit_data, frame[NBITS-1:1]};
              if (bit_cnt == CNT_W'(NBITS - 1)) begin
                state   <= ST_CHECK;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          ST_CHECK: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (frame_ok) begin
              temp_valid <= 1'b1;
              temp_raw   <= raw_next;
              temp_deg   <= deg_next;
            end else begin
              crc_err <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ds18b20_frame_check.sv
// Directed self-checking bench for ds18b20_frame_check; expected temperatures
// follow the DS18B20_ROUND_EN setting of the build.
module tb_ds18b20_frame_check;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_data = 1'b0;
  logic        busy, temp_valid, crc_err;
  logic [15:0] temp_raw;
  logic [7:0]  temp_deg;

  int checks = 0;
  int failures = 0;
  int tv_cnt = 0, ce_cnt = 0, both_cnt = 0;
  logic [15:0] held_raw = 16'h0000;
  logic [7:0]  held_deg = 8'h00;

  localparam logic [71:0] POWER_ON = 72'h1C_10_0C_FF_7F_46_4B_05_50;
  localparam logic [71:0] BAD_BIT3 = 72'h1C_10_0C_FF_7F_46_4B_05_58;

  always #10 clk_in = ~clk_in;

  ds18b20_frame_check dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .bit_valid   (bit_valid),
    .bit_data    (bit_data),
    .busy        (busy),
    .temp_valid  (temp_valid),
    .crc_err     (crc_err),
    .temp_raw    (temp_raw),
    .temp_deg    (temp_deg)
  );

  always @(negedge clk_in) begin
    if (temp_valid) tv_cnt++;
    if (crc_err) ce_cnt++;
    if (temp_valid && crc_err) both_cnt++;
  end

  function automatic logic [7:0] crc_of(input logic [63:0] d);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int i = 0; i < 64; i++) begin
      fb = c[0] ^ d[i];
      c  = (c >> 1) ^ (fb ? 8'h8C : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [71:0] make_frame(input logic [15:0] raw);
    logic [63:0] d;
    d = {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, raw[15:8], raw[7:0]};
    return {crc_of(d), d};
  endfunction

  // Caller is at a negedge; returns at a negedge with frame_start low.
  task automatic start_frame();
    frame_start = 1'b1;
    @(negedge clk_in);
    frame_start = 1'b0;
  endtask

  task automatic send_bits(input logic [71:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bit_data  = f[i];
      @(negedge clk_in);
    end
    bit_valid = 1'b0;
    bit_data  = 1'b0;
  endtask

  // Called in the CHECK cycle (right after the edge that sampled the last bit).
  task automatic expect_result(input string name, input logic good,
                               input logic [15:0] raw, input logic [7:0] deg);
    int tv0, ce0;
    tv0 = tv_cnt;
    ce0 = ce_cnt;
    checks++;
    if ({busy, temp_valid, crc_err} !== 3'b100) begin
      failures++;
      $display("FAIL %s check_cycle busy/tv/ce got=%b exp=100", name, {busy, temp_valid, crc_err});
    end
    @(negedge clk_in);
    checks++;
    if ({busy, temp_valid, crc_err} !== {1'b0, good, !good}) begin
      failures++;
      $display("FAIL %s result busy/tv/ce got=%b exp=%b", name, {busy, temp_valid, crc_err}, {1'b0, good, !good});
    end
    if (good) begin
      held_raw = raw;
      held_deg = deg;
    end
    checks++;
    if (temp_raw !== held_raw || temp_deg !== held_deg) begin
      failures++;
      $display("FAIL %s outputs raw=%h deg=%h exp raw=%h deg=%h", name, temp_raw, temp_deg, held_raw, held_deg);
    end
    @(negedge clk_in);
    checks++;
    if ({busy, temp_valid, crc_err} !== 3'b000 || tv_cnt - tv0 != int'(good) || ce_cnt - ce0 != int'(!good)) begin
      failures++;
      $display("FAIL %s single_pulse flags=%b tv_pulses=%0d ce_pulses=%0d exp tv=%0d ce=%0d",
               name, {busy, temp_valid, crc_err}, tv_cnt - tv0, ce_cnt - ce0, int'(good), int'(!good));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({busy, temp_valid, crc_err, temp_raw, temp_deg} !== 27'd0) begin
      failures++;
      $display("FAIL reset_state got busy=%b tv=%b ce=%b raw=%h deg=%h exp all zero",
               busy, temp_valid, crc_err, temp_raw, temp_deg);
    end
    rst_n = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_idle_ignore();
    send_bits(72'hFF, 8);
    checks++;
    if ({busy, temp_valid, crc_err} !== 3'b000) begin
      failures++;
      $display("FAIL idle_ignore busy/tv/ce got=%b exp=000", {busy, temp_valid, crc_err});
    end
  endtask

  task automatic test_power_on();
    start_frame();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_rise got=%b exp=1", busy);
    end
    send_bits(POWER_ON, 72);
    expect_result("power_on", 1'b1, 16'h0550, 8'd85);
  endtask

  task automatic test_crc_error();
    start_frame();
    send_bits(BAD_BIT3, 72);
    expect_result("crc_error", 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic test_conversion();
    logic [7:0] exp_neg;
`ifdef DS18B20_ROUND_EN
    exp_neg = 8'hF6;
`else
    exp_neg = 8'hF5;
`endif
    start_frame();
    send_bits(make_frame(16'hFF5E), 72);
    expect_result("conv_neg", 1'b1, 16'hFF5E, exp_neg);
    start_frame();
    send_bits(make_frame(16'h0191), 72);
    expect_result("conv_25", 1'b1, 16'h0191, 8'd25);
  endtask

  task automatic test_all_zero();
    start_frame();
    send_bits(72'h0, 72);
    expect_result("all_zero", 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic test_abort();
    int tv0, ce0;
    tv0 = tv_cnt;
    ce0 = ce_cnt;
    start_frame();
    send_bits(make_frame(16'hFF5E), 40);
    start_frame();
    send_bits(POWER_ON, 72);
    expect_result("abort_restart", 1'b1, 16'h0550, 8'd85);
    checks++;
    if (tv_cnt - tv0 != 1 || ce_cnt - ce0 != 0) begin
      failures++;
      $display("FAIL abort_pulse_count tv=%0d ce=%0d exp tv=1 ce=0", tv_cnt - tv0, ce_cnt - ce0);
    end
  endtask

  task automatic test_coincident_start();
    start_frame();
    send_bits(POWER_ON, 10);
    frame_start = 1'b1;
    bit_valid   = 1'b1;
    bit_data    = 1'b1;
    @(negedge clk_in);
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    send_bits(make_frame(16'h0191), 72);
    expect_result("coincident_start", 1'b1, 16'h0191, 8'd25);
  endtask

  task automatic test_abort_in_check();
    int tv0, ce0;
    tv0 = tv_cnt;
    ce0 = ce_cnt;
    start_frame();
    send_bits(make_frame(16'hFF5E), 72);
    start_frame();
    checks++;
    if ({busy, temp_valid, crc_err} !== 3'b100) begin
      failures++;
      $display("FAIL abort_in_check busy/tv/ce got=%b exp=100", {busy, temp_valid, crc_err});
    end
    send_bits(POWER_ON, 72);
    expect_result("after_check_abort", 1'b1, 16'h0550, 8'd85);
    checks++;
    if (tv_cnt - tv0 != 1 || ce_cnt - ce0 != 0) begin
      failures++;
      $display("FAIL check_abort_pulse_count tv=%0d ce=%0d exp tv=1 ce=0", tv_cnt - tv0, ce_cnt - ce0);
    end
  endtask

  task automatic test_reset_mid_frame();
    start_frame();
    send_bits(make_frame(16'h0191), 60);
    bit_valid = 1'b1;
    bit_data  = 1'b1;
    #5 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, temp_valid, crc_err, temp_raw, temp_deg} !== 27'd0) begin
      failures++;
      $display("FAIL async_reset got busy=%b tv=%b ce=%b raw=%h deg=%h exp all zero",
               busy, temp_valid, crc_err, temp_raw, temp_deg);
    end
    held_raw  = 16'h0000;
    held_deg  = 8'h00;
    bit_valid = 1'b0;
    bit_data  = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
    start_frame();
    send_bits(make_frame(16'h0191), 72);
    expect_result("after_reset", 1'b1, 16'h0191, 8'd25);
  endtask

  initial begin
    @(negedge clk_in);
    test_reset();
    test_idle_ignore();
    test_power_on();
    test_crc_error();
    test_conversion();
    test_all_zero();
    test_abort();
    test_coincident_start();
    test_abort_in_check();
    test_reset_mid_frame();
    checks++;
    if (both_cnt != 0) begin
      failures++;
      $display("FAIL exclusive_pulses both_high_cycles=%0d exp=0", both_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
